// File: rtl/timebase_pkg.sv
// Shared types and default ratios for the alarm-clock time-base generator.
// Also provides the counter-width helper used by the counter and the top-level ports.
package timebase_pkg;

    typedef enum logic [1:0] {
        TB_NORMAL = 2'b00,
        TB_FAST   = 2'b01
    } tb_mode_e;

    localparam int DEF_CLK_PER_SEC  = 256;
    localparam int DEF_SEC_PER_MIN  = 60;
    localparam int DEF_MIN_PER_HOUR = 60;

    // Width needed to hold 0..modulus-1, never less than one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus > 2) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/timebase_gen_mod_counter.sv
// Modulo-N up-counter with synchronous clear and increment enable.
// terminal flags the last count; an increment at terminal wraps to zero.
module mod_counter
    import timebase_pkg::*;
#(
    parameter int MODULUS = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clr,
    input  logic                           inc,
    output logic [cnt_width(MODULUS)-1:0]  value,
    output logic                           terminal
);

    localparam int             W    = cnt_width(MODULUS);
    localparam logic [W-1:0]   LAST = W'(MODULUS - 1);
    localparam logic [W-1:0]   ONE  = W'(1);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    assign terminal = (value_q == LAST);
    assign value    = value_q;

    // Clear has priority over increment so a reload never lets a wrap through.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            if (terminal) begin
                value_d = '0;
            end else begin
                value_d = value_q + ONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/timebase_gen.sv
// Time-base generator: divides the system clock into second, minute and hour pulses
// with pause, reload clear and a fast mode where one "minute" lasts one second.
module timebase_gen
    import timebase_pkg::*;
#(
    parameter int CLK_PER_SEC  = DEF_CLK_PER_SEC,
    parameter int SEC_PER_MIN  = DEF_SEC_PER_MIN,
    parameter int MIN_PER_HOUR = DEF_MIN_PER_HOUR
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                reset_count,
    input  logic                                enable,
    input  logic [1:0]                          mode,
    output logic                                one_second,
    output logic                                one_minute,
    output logic                                one_hour,
    output logic [cnt_width(SEC_PER_MIN)-1:0]   sec_index,
    output logic [cnt_width(MIN_PER_HOUR)-1:0]  min_index
);

    localparam int CYC_W = cnt_width(CLK_PER_SEC);
    localparam int SEC_W = cnt_width(SEC_PER_MIN);
    localparam int MIN_W = cnt_width(MIN_PER_HOUR);

    logic [CYC_W-1:0] cyc_cnt;
    logic [SEC_W-1:0] sec_cnt;
    logic [MIN_W-1:0] min_cnt;
    logic             cyc_last;
    logic             sec_last;
    logic             min_last;

    logic sec_tick;
    logic min_tick_n;
    logic fast;
    logic eff_min_tick;
    logic hour_tick;

    logic one_second_q;
    logic one_second_d;
    logic one_minute_reg_q;
    logic one_minute_reg_d;
    logic one_hour_q;
    logic one_hour_d;

    // Terminal-count events; every one of them is gated by enable through sec_tick.
    assign sec_tick     = enable & cyc_last;
    assign min_tick_n   = sec_tick & sec_last;
    assign fast         = (mode == TB_FAST);
    assign eff_min_tick = fast ? sec_tick : min_tick_n;
    assign hour_tick    = eff_min_tick & min_last;

    mod_counter #(
        .MODULUS (CLK_PER_SEC)
    ) u_cyc (
        .clock    (clock),
        .reset    (reset),
        .clr      (reset_count),
        .inc      (enable),
        .value    (cyc_cnt),
        .terminal (cyc_last)
    );

    mod_counter #(
        .MODULUS (SEC_PER_MIN)
    ) u_sec (
        .clock    (clock),
        .reset    (reset),
        .clr      (reset_count),
        .inc      (sec_tick),
        .value    (sec_cnt),
        .terminal (sec_last)
    );

    // In fast mode the minute counter advances every second, so hours come MIN_PER_HOUR seconds apart.
    mod_counter #(
        .MODULUS (MIN_PER_HOUR)
    ) u_min (
        .clock    (clock),
        .reset    (reset),
        .clr      (reset_count),
        .inc      (eff_min_tick),
        .value    (min_cnt),
        .terminal (min_last)
    );

    always_comb begin
        one_second_d     = sec_tick;
        one_minute_reg_d = min_tick_n;
        one_hour_d       = hour_tick;
        if (reset_count) begin
            one_second_d     = 1'b0;
            one_minute_reg_d = 1'b0;
            one_hour_d       = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            one_second_q     <= 1'b0;
            one_minute_reg_q <= 1'b0;
            one_hour_q       <= 1'b0;
        end else begin
            one_second_q     <= one_second_d;
            one_minute_reg_q <= one_minute_reg_d;
            one_hour_q       <= one_hour_d;
        end
    end

    // The minute selection follows mode combinationally so a mode switch takes effect at once.
    assign one_second = one_second_q;
    assign one_minute = fast ? one_second_q : one_minute_reg_q;
    assign one_hour   = one_hour_q;
    assign sec_index  = sec_cnt;
    assign min_index  = min_cnt;

endmodule

// File: tb/tb_timebase_gen.sv
// Self-checking bench for timebase_gen: a default-ratio instance and a small-ratio instance,
// both compared every cycle against a behavioural scoreboard plus directed edge checks.
module tb_timebase_gen;

    logic       clock;
    logic       reset;
    logic       reset_count;
    logic       enable;
    logic [1:0] mode;

    logic       os_a, om_a, oh_a;
    logic [5:0] si_a, mi_a;
    logic       os_b, om_b, oh_b;
    logic [1:0] si_b;
    logic [0:0] mi_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int sec;
        int mn;
        bit os;
        bit omr;
        bit oh;
    } mstate_t;

    typedef struct {
        bit os;
        bit om;
        bit oh;
        int si;
        int mi;
    } exp_t;

    mstate_t st_a, st_b;
    exp_t    q_a[$];
    exp_t    q_b[$];

    timebase_gen u_a (
        .clock       (clock),
        .reset       (reset),
        .reset_count (reset_count),
        .enable      (enable),
        .mode        (mode),
        .one_second  (os_a),
        .one_minute  (om_a),
        .one_hour    (oh_a),
        .sec_index   (si_a),
        .min_index   (mi_a)
    );

    timebase_gen #(
        .CLK_PER_SEC  (4),
        .SEC_PER_MIN  (3),
        .MIN_PER_HOUR (2)
    ) u_b (
        .clock       (clock),
        .reset       (reset),
        .reset_count (reset_count),
        .enable      (enable),
        .mode        (mode),
        .one_second  (os_b),
        .one_minute  (om_b),
        .one_hour    (oh_b),
        .sec_index   (si_b),
        .min_index   (mi_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic mstate_t mzero();
        mstate_t z;
        z.cyc = 0; z.sec = 0; z.mn = 0;
        z.os = 1'b0; z.omr = 1'b0; z.oh = 1'b0;
        return z;
    endfunction

    function automatic mstate_t mstep(mstate_t s, int cps, int spm, int mph,
                                      bit en, bit rc, bit [1:0] md);
        mstate_t n;
        bit st, mt, fst, emt, ht;
        n   = s;
        st  = en && (s.cyc == cps - 1);
        mt  = st && (s.sec == spm - 1);
        fst = (md == 2'b01);
        emt = fst ? st : mt;
        ht  = emt && (s.mn == mph - 1);
        if (rc) begin
            n = mzero();
        end else begin
            if (en) begin
                n.cyc = st ? 0 : s.cyc + 1;
                if (st)  n.sec = mt ? 0 : s.sec + 1;
                if (emt) n.mn  = ht ? 0 : s.mn + 1;
            end
            n.os  = st;
            n.omr = mt;
            n.oh  = ht;
        end
        return n;
    endfunction

    function automatic exp_t to_exp(mstate_t s, bit [1:0] md);
        exp_t e;
        e.os = s.os;
        e.om = (md == 2'b01) ? s.os : s.omr;
        e.oh = s.oh;
        e.si = s.sec;
        e.mi = s.mn;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_os"}, 32'(os_a), 0);
        chk({tag, "_a_om"}, 32'(om_a), 0);
        chk({tag, "_a_oh"}, 32'(oh_a), 0);
        chk({tag, "_a_si"}, 32'(si_a), 0);
        chk({tag, "_a_mi"}, 32'(mi_a), 0);
        chk({tag, "_b_os"}, 32'(os_b), 0);
        chk({tag, "_b_om"}, 32'(om_b), 0);
        chk({tag, "_b_oh"}, 32'(oh_b), 0);
        chk({tag, "_b_si"}, 32'(si_b), 0);
        chk({tag, "_b_mi"}, 32'(mi_b), 0);
    endtask

    // Push the expected post-edge outputs, take the edge, then pop and compare.
    task automatic tick();
        exp_t ea, eb;
        st_a = mstep(st_a, 256, 60, 60, enable, reset_count, mode);
        st_b = mstep(st_b, 4, 3, 2, enable, reset_count, mode);
        q_a.push_back(to_exp(st_a, mode));
        q_b.push_back(to_exp(st_b, mode));
        @(posedge clock);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        chk("sb_a_os", 32'(os_a), 32'(ea.os));
        chk("sb_a_om", 32'(om_a), 32'(ea.om));
        chk("sb_a_oh", 32'(oh_a), 32'(ea.oh));
        chk("sb_a_si", 32'(si_a), 32'(ea.si));
        chk("sb_a_mi", 32'(mi_a), 32'(ea.mi));
        chk("sb_b_os", 32'(os_b), 32'(eb.os));
        chk("sb_b_om", 32'(om_b), 32'(eb.om));
        chk("sb_b_oh", 32'(oh_b), 32'(eb.oh));
        chk("sb_b_si", 32'(si_b), 32'(eb.si));
        chk("sb_b_mi", 32'(mi_b), 32'(eb.mi));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        st_a = mzero();
        st_b = mzero();
        q_a.delete();
        q_b.delete();
        #1;
        check_zero({tag, "_async"});
        @(posedge clock);
        #1;
        check_zero({tag, "_held"});
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        reset_count = 1'b0;
        enable      = 1'b1;
        mode        = 2'b00;
        st_a        = mzero();
        st_b        = mzero();

        // Phase 1: normal mode, both ratio sets, default minute boundary.
        do_reset("p1_rst");
        for (int e = 1; e <= 15361; e++) begin
            tick();
            if (e == 255)   chk("p1_a_sec_early", 32'(os_a), 0);
            if (e == 256) begin
                chk("p1_a_sec_first", 32'(os_a), 1);
                chk("p1_a_si_first", 32'(si_a), 1);
            end
            if (e == 512)   chk("p1_a_sec_second", 32'(os_a), 1);
            if (e == 15359) chk("p1_a_min_early", 32'(om_a), 0);
            if (e == 15360) chk("p1_a_min_first", 32'(om_a), 1);
            if (e == 4)     chk("p1_b_sec", 32'(os_b), 1);
            if (e == 12) begin
                chk("p1_b_min", 32'(om_b), 1);
                chk("p1_b_hour_none", 32'(oh_b), 0);
                chk("p1_b_mi_one", 32'(mi_b), 1);
            end
            if (e == 24) begin
                chk("p1_b_hour", 32'(oh_b), 1);
                chk("p1_b_mi_zero", 32'(mi_b), 0);
            end
        end

        // Phase 2: fast mode, then a mid-count switch back to normal.
        do_reset("p2_rst");
        mode = 2'b01;
        for (int e = 1; e <= 30; e++) begin
            tick();
            chk("p2_b_fast_om", 32'(om_b), 32'(os_b));
            if (e == 4)  chk("p2_b_min_fast", 32'(om_b), 1);
            if (e == 7)  chk("p2_b_hour_early", 32'(oh_b), 0);
            if (e == 8) begin
                chk("p2_b_hour", 32'(oh_b), 1);
                chk("p2_b_si_two", 32'(si_b), 2);
            end
            if (e == 12) chk("p2_b_si_wrap", 32'(si_b), 0);
        end
        mode = 2'b00;
        for (int e = 1; e <= 30; e++) tick();
        mode = 2'b10;
        for (int e = 1; e <= 30; e++) tick();

        // Phase 3: pause for 100 cycles starting at cyc_cnt == 100.
        mode = 2'b00;
        do_reset("p3_rst");
        for (int e = 1; e <= 100; e++) tick();
        enable = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            chk("p3_a_paused_sec", 32'(os_a), 0);
        end
        enable = 1'b1;
        for (int e = 201; e <= 360; e++) begin
            tick();
            if (e == 355) chk("p3_a_sec_early", 32'(os_a), 0);
            if (e == 356) chk("p3_a_sec_resume", 32'(os_a), 1);
        end

        // Phase 4: reset_count collides with the terminal count.
        do_reset("p4_rst");
        for (int e = 1; e <= 255; e++) tick();
        reset_count = 1'b1;
        tick();
        chk("p4_a_rc_sec", 32'(os_a), 0);
        chk("p4_a_rc_si", 32'(si_a), 0);
        reset_count = 1'b0;
        for (int e = 1; e <= 256; e++) begin
            tick();
            if (e == 255) chk("p4_a_sec_early", 32'(os_a), 0);
            if (e == 256) chk("p4_a_sec_after_rc", 32'(os_a), 1);
        end

        // Phase 5: reset_count while paused, then async reset mid-count and restart.
        enable      = 1'b0;
        reset_count = 1'b1;
        tick();
        reset_count = 1'b0;
        enable      = 1'b1;
        mode        = 2'b01;
        for (int e = 1; e <= 50; e++) tick();
        do_reset("p5_rst");
        mode = 2'b00;
        for (int e = 1; e <= 260; e++) begin
            tick();
            if (e == 256) chk("p5_a_sec_restart", 32'(os_a), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
